// File: rtl/audio_pkg.sv
// Shared audio-path constants and the sampler FSM state type.
package audio_pkg;

  localparam int CODE_WIDTH = 10;
  localparam int WINDOW_LEN = 1 << CODE_WIDTH;
  localparam int MID_SCALE  = 512;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ph_t;

endpackage

// File: rtl/pwm_core.sv
// PWM comparator: output is high for the first `duty` counts of each window.
module pwm_core #(
  parameter int CODE_WIDTH = audio_pkg::CODE_WIDTH
) (
  input  logic                  run,
  input  logic [CODE_WIDTH-1:0] cnt,
  input  logic [CODE_WIDTH-1:0] duty,
  output logic                  pwm
);

  assign pwm = run && (cnt < duty);

endmodule

// File: rtl/pwm_dac_sampler.sv
// NCO sample consumer: requests one code per SAMPLE_DIV PWM windows, latches it
// one cycle after the request and plays it out as a PWM duty.
//
// state | meaning
// IDLE  | paused, outputs muted, counters cleared, duty held
// RUN   | window counter running, PWM active, samples fetched
module pwm_dac_sampler #(
  parameter int CODE_WIDTH = audio_pkg::CODE_WIDTH,
  parameter int SAMPLE_DIV = 1,
  parameter int RST_DUTY   = audio_pkg::MID_SCALE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  next_sample,
  output logic                  pwm,
  output logic                  window_start,
  output logic [CODE_WIDTH-1:0] duty
);

  import audio_pkg::*;

  localparam int DIV_W = $clog2(SAMPLE_DIV) + 1;
  localparam logic [CODE_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CODE_WIDTH-1:0] CNT_REQ  = CNT_MAX - CODE_WIDTH'(1);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  ph_t                   ph;
  logic [CODE_WIDTH-1:0] cnt;
  logic [CODE_WIDTH-1:0] duty_q;
  logic [DIV_W-1:0]      div;
  logic                  run;
  logic                  last_win;
  logic                  capture;

  assign run          = (ph == RUN);
  assign last_win     = (div == DIV_LAST);
  assign next_sample  = run && (cnt == CNT_REQ) && last_win;
  assign window_start = run && (cnt == '0);
  assign duty         = duty_q;

  // Code is valid only in the cycle after the request; a pause on that edge skips it.
  assign capture = run && en && (cnt == CNT_MAX) && last_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph     <= IDLE;
      cnt    <= '0;
      div    <= '0;
      duty_q <= CODE_WIDTH'(RST_DUTY);
    end else begin
      case (ph)
        IDLE: begin
          if (en) ph <= RUN;
        end
        RUN: begin
          if (!en) begin
            ph  <= IDLE;
            cnt <= '0;
            div <= '0;
          end else begin
            cnt <= cnt + CODE_WIDTH'(1);
            if (cnt == CNT_MAX) div <= last_win ? '0 : div + DIV_W'(1);
            if (capture) duty_q <= code;
          end
        end
        default: ph <= IDLE;
      endcase
    end
  end

  pwm_core #(
    .CODE_WIDTH (CODE_WIDTH)
  ) u_pwm_core (
    .run  (run),
    .cnt  (cnt),
    .duty (duty_q),
    .pwm  (pwm)
  );

endmodule

// File: tb/tb_pwm_dac_sampler.sv
// Directed bench for pwm_dac_sampler: one instance with SAMPLE_DIV=1, one with SAMPLE_DIV=4.
module tb_pwm_dac_sampler;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] code = '0;
  logic         next_sample, pwm, window_start;
  logic [W-1:0] duty;

  logic         en4 = 1'b0;
  logic [W-1:0] code4 = '0;
  logic         next_sample4, pwm4, window_start4;
  logic [W-1:0] duty4;

  always #4 clk = ~clk;

  pwm_dac_sampler #(.CODE_WIDTH(W), .SAMPLE_DIV(1), .RST_DUTY(512)) dut (
    .clk (clk), .rst (rst), .en (en), .code (code),
    .next_sample (next_sample), .pwm (pwm), .window_start (window_start), .duty (duty)
  );

  pwm_dac_sampler #(.CODE_WIDTH(W), .SAMPLE_DIV(4), .RST_DUTY(512)) dut4 (
    .clk (clk), .rst (rst), .en (en4), .code (code4),
    .next_sample (next_sample4), .pwm (pwm4), .window_start (window_start4), .duty (duty4)
  );

  typedef struct {
    int code;
    int exp_high;
    int exp_duty;
  } vec_t;

  vec_t tbl[7];
  vec_t tbl4[3];

  int nchk = 0;
  int nerr = 0;

  // NCO model: valid code only in the cycle after a request, a distinct junk value otherwise
  logic [W-1:0] nco_code = '0, nco_code4 = '0;
  logic         pend = 1'b0, pend4 = 1'b0;

  int hi[4], hi4[4];
  int ns_cnt, ns_pos, ws_cnt;
  int ns4_cnt, ns4_pos, ws4_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample the current cycle, drive the NCO for it, then advance one clock; n <= 4096.
  task automatic run_n(input int n);
    for (int k = 0; k < 4; k++) begin
      hi[k] = 0;
      hi4[k] = 0;
    end
    ns_cnt = 0; ns_pos = -1; ws_cnt = 0;
    ns4_cnt = 0; ns4_pos = -1; ws4_cnt = 0;
    for (int i = 0; i < n; i++) begin
      code  = pend  ? nco_code  : (nco_code  ^ 10'h2A5);
      code4 = pend4 ? nco_code4 : (nco_code4 ^ 10'h2A5);
      if (pwm)  hi[i / 1024]++;
      if (pwm4) hi4[i / 1024]++;
      if (next_sample)  begin ns_cnt++;  ns_pos  = i; end
      if (next_sample4) begin ns4_cnt++; ns4_pos = i; end
      if (window_start)  ws_cnt++;
      if (window_start4) ws4_cnt++;
      pend  = next_sample;
      pend4 = next_sample4;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tbl[0] = '{code: 'h300, exp_high: 512, exp_duty: 768};
    tbl[1] = '{code: 0,     exp_high: 768, exp_duty: 0};
    tbl[2] = '{code: 1023,  exp_high: 0,   exp_duty: 1023};
    tbl[3] = '{code: 0,     exp_high: 1023, exp_duty: 0};
    tbl[4] = '{code: 1,     exp_high: 0,   exp_duty: 1};
    tbl[5] = '{code: 200,   exp_high: 1,   exp_duty: 200};
    tbl[6] = '{code: 512,   exp_high: 200, exp_duty: 512};

    tbl4[0] = '{code: 300, exp_high: 512, exp_duty: 300};
    tbl4[1] = '{code: 700, exp_high: 300, exp_duty: 700};
    tbl4[2] = '{code: 50,  exp_high: 700, exp_duty: 50};

    // reset and release
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", pwm, 0);
    check("rst_duty", duty, 512);
    check("rst_duty4", duty4, 512);
    #3 rst = 1'b1;
    #1;
    check("post_rel_ns", next_sample, 0);
    check("post_rel_pwm", pwm, 0);
    check("post_rel_ws", window_start, 0);
    @(posedge clk); #1;

    // en held low
    run_n(2000);
    check("idle_pwm_hi", hi[0] + hi[1], 0);
    check("idle_ns", ns_cnt, 0);
    check("idle_ws", ws_cnt, 0);
    check("idle_pwm4_hi", hi4[0] + hi4[1], 0);
    check("idle_duty", duty, 512);

    // start and table-driven windows
    en = 1'b1;
    check("idle_ws_before_run", window_start, 0);
    run_n(1);
    check("run_first_ws", window_start, 1);
    for (int w = 0; w < 7; w++) begin
      nco_code = W'(tbl[w].code);
      run_n(1024);
      check($sformatf("win%0d_high", w), hi[0], tbl[w].exp_high);
      check($sformatf("win%0d_ns_cnt", w), ns_cnt, 1);
      check($sformatf("win%0d_ns_pos", w), ns_pos, 1022);
      check($sformatf("win%0d_ws_cnt", w), ws_cnt, 1);
      check($sformatf("win%0d_duty", w), duty, tbl[w].exp_duty);
    end

    // pause on the request cycle: sample skipped, duty held
    nco_code = W'(341);
    run_n(1022);
    check("drop_ns_seen", next_sample, 1);
    code = nco_code ^ 10'h2A5;
    en = 1'b0;
    pend = 1'b1;
    @(posedge clk); #1;
    check("drop_pwm", pwm, 0);
    check("drop_ns", next_sample, 0);
    check("drop_duty", duty, 512);
    run_n(5);
    check("drop_duty_held", duty, 512);
    en = 1'b1;
    check("resume_ws_pre", window_start, 0);
    run_n(1);
    check("resume_ws", window_start, 1);
    nco_code = W'(800);
    run_n(1024);
    check("resume_high", hi[0], 512);
    check("resume_ns_pos", ns_pos, 1022);
    check("resume_duty", duty, 800);

    // reset mid-window while pwm is high
    run_n(600);
    check("mid_pwm_high", pwm, 1);
    #2 rst = 1'b0;
    #1;
    check("async_pwm", pwm, 0);
    check("async_duty", duty, 512);
    check("async_ns", next_sample, 0);
    check("async_ws", window_start, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("in_rst_pwm", pwm, 0);
    #3 rst = 1'b1;
    #1;
    check("rel2_ws", window_start, 0);
    check("rel2_pwm", pwm, 0);
    pend = 1'b0;
    pend4 = 1'b0;
    @(posedge clk); #1;
    nco_code = W'('h300);
    run_n(1024);
    check("rerun_high", hi[0], 512);
    check("rerun_ns_pos", ns_pos, 1022);
    check("rerun_ns_cnt", ns_cnt, 1);
    check("rerun_duty", duty, 768);

    // SAMPLE_DIV=4 instance
    en = 1'b0;
    en4 = 1'b1;
    run_n(1);
    check("div4_first_ws", window_start4, 1);
    for (int g = 0; g < 3; g++) begin
      nco_code4 = W'(tbl4[g].code);
      run_n(4096);
      for (int k = 0; k < 4; k++)
        check($sformatf("div4_g%0d_w%0d_high", g, k), hi4[k], tbl4[g].exp_high);
      check($sformatf("div4_g%0d_ns_cnt", g), ns4_cnt, 1);
      check($sformatf("div4_g%0d_ns_pos", g), ns4_pos, 4094);
      check($sformatf("div4_g%0d_ws_cnt", g), ws4_cnt, 4);
      check($sformatf("div4_g%0d_duty", g), duty4, tbl4[g].exp_duty);
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pwm_dac_sampler.md
Name: pwm_dac_sampler

Overview:
- Consumer end of the NCO sample interface. Pulses `next_sample` once per sample window and latches the returned `code` one cycle later.
- Converts the latched code to a PWM bitstream at `clk` rate. Sits between the NCO and the audio output pin.
- With defaults (125 MHz clock, 1024-cycle window) it fetches one sample every 1024 cycles, which is about 122 kHz.
- Sample cadence is deterministic, unlike the randomized pull pattern used when verifying the NCO alone.

Parameters:
- CODE_WIDTH, 10, width of the NCO code; PWM window length is 2^CODE_WIDTH cycles.
- SAMPLE_DIV, 1, number of PWM windows per fetched sample (≥1); the same duty is repeated for SAMPLE_DIV windows.
- RST_DUTY, 512, duty loaded at reset (mid-scale, equal to NCO LUT[0]).

Ports:
- clk  in  1  system clock, 125 MHz
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- en  in  1  run enable; low = paused/muted
- code  in  CODE_WIDTH  sample from the NCO; must be valid in the cycle after `next_sample` is high
- next_sample  out  1  one-cycle request to the NCO to advance to its next sample
- pwm  out  1  PWM output
- window_start  out  1  one-cycle strobe, high in the cycle `cnt == 0` while running
- duty  out  CODE_WIDTH  currently applied duty value, for debug and verification

Behaviour:
- State:
  - `cnt` is a CODE_WIDTH-bit window counter.
  - `div` is a window counter covering 0..SAMPLE_DIV-1, sized $clog2(SAMPLE_DIV)+1.
  - `duty_q` is CODE_WIDTH bits.
  - `ph` is a 2-state FSM: IDLE, RUN.
- Reset (rst=0, asynchronous): `cnt`=0, `div`=0, `duty_q`=RST_DUTY, `ph`=IDLE. All outputs (`next_sample`, `pwm`, `window_start`) are 0 during reset and on the first cycle after release. `duty` shows RST_DUTY.
- FSM transitions:
  - IDLE→RUN on the edge where `en`=1. `cnt` stays 0.
  - RUN→IDLE on any edge where `en`=0. `cnt` and `div` clear to 0; `duty_q` is held.
- RUN counter update:
  - `cnt` increments every cycle and wraps from 2^W-1 to 0.
  - `div` increments each time `cnt` wraps and itself wraps at SAMPLE_DIV-1.
- `next_sample` is combinational from flops: high iff RUN && `cnt`==2^W-2 && `div`==SAMPLE_DIV-1. It is exactly one cycle wide, never high in IDLE, and never high in two consecutive cycles.
- Capture:
  - On the edge ending the cycle where RUN && `cnt`==2^W-1 && `div`==SAMPLE_DIV-1, `duty_q` <= `code`.
  - Latency from the `next_sample` cycle to capture is exactly 2 edges.
  - The new duty applies from the next window's `cnt`=0.
- PWM:
  - `pwm` = RUN && (`cnt` < `duty_q`), driven from flops with no combinational path from `code`.
  - Per window, `pwm` is high for exactly `duty_q` cycles starting at `cnt`=0.
  - `code`=0 gives `pwm` constantly low; `code`=2^W-1 gives `pwm` high 1023 of 1024 cycles (W=10).
- `window_start` = RUN && `cnt`==0.
- Boundary conditions:
  - `en` dropping on the cycle `next_sample`=1: the request has been issued and the NCO advances, but no capture occurs. This sample is skipped; it is not an error.
  - `en` rising again: the window restarts at `cnt`=0 using the held `duty_q`.
  - Reset mid-window: immediate return to the reset state; no partial `next_sample` pulse.
  - `code` changing outside the capture edge: ignored.

Decomposition:
- Shared package `audio_pkg` holds:
  - CODE_WIDTH, consistent with the NCO's 10-bit code;
  - the window length constant (2^CODE_WIDTH);
  - the mid-scale constant (512);
  - the FSM state typedef {IDLE, RUN}.
- One natural sub-module, `pwm_core`: takes `cnt` and `duty_q`, produces `pwm`, with the comparator isolated.
- Request/capture sequencing stays in the top level.

Test Plan:
- Reset, then hold en=0 for 2000 cycles → `next_sample`, `pwm`, and `window_start` stay 0; `duty`=512.
- en=1 with the NCO model returning 10'h300 → first `next_sample` at RUN cycle 1022 (cnt=1022), `duty`=768 after the cnt=1023 edge; the next window has `pwm` high for exactly 768 cycles.
- Codes 0 and 1023 → `pwm` never high, then high 1023/1024 cycles; 0 and 1 captured in successive windows → 0 then 1 high cycle.
- SAMPLE_DIV=4 with a 3-window run → exactly 1 `next_sample` per 4096 cycles; the duty is repeated identically across the 4 windows.
- Drop en in the `next_sample` cycle → `duty` unchanged, `pwm` low next cycle; en=1 again → `window_start` on the 2nd cycle after, first request 1022 cycles later.
- Assert rst at cnt=600 with `pwm` high → `pwm`=0 asynchronously and `duty`=512; after release, the sequence repeats from scenario 2.
